// File: rtl/search_controller_pkg.sv
// search_controller_pkg: shared widths, state encoding and lane priority helper for the MD5 search controller.
package search_controller_pkg;
  localparam int LANES = 8;
  localparam int LANE_BITS = 3;
  localparam int COUNT_W = 29;
  localparam int PIPE_DEPTH_DEF = 65;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAUSE     = 3'd2,
    S_DRAIN     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;
  function automatic logic [LANE_BITS-1:0] lowest_lane(input logic [LANES-1:0] m);
    lowest_lane = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (m[i]) lowest_lane = LANE_BITS'(i);
  endfunction
endpackage

// File: rtl/search_controller_count_history.sv
// search_controller_count_history: fixed-latency delay line of issued counts; only the valid bits are cleared so the data can map to shift-register primitives.
module search_controller_count_history #(
  parameter int DEPTH = 65,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_data
);
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] data [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) vld <= '0;
    else vld <= {vld[DEPTH-2:0], in_valid};
  always_ff @(posedge clk) begin
    data[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data[i] <= data[i-1];
  end
  assign tail_valid = vld[DEPTH-1];
  assign tail_data = data[DEPTH-1];
endmodule

// File: rtl/search_controller.sv
// search_controller: gates the candidate counter, recovers the matching {count,lane} candidate and detects keyspace exhaustion.
module search_controller
  import search_controller_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               enable_switch,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               counter_done,
  input  logic [LANES-1:0]   found_in,
  output logic               counter_en,
  output logic               running,
  output logic               found,
  output logic               exhausted,
  output logic [31:0]        result,
  output logic [LANES-1:0]   found_mask
);
  localparam int DW = $clog2(PIPE_DEPTH + 1);
  state_t state;
  logic [DW-1:0] drain_cnt;
  logic tail_valid, active, hit;
  logic [COUNT_W-1:0] tail_count;
  assign active = state inside {S_RUN, S_PAUSE, S_DRAIN};
  search_controller_count_history #(.DEPTH(PIPE_DEPTH), .WIDTH(COUNT_W)) u_history (
    .clk       (CLK),
    .rst       (reset),
    .in_valid  (active),
    .in_data   (count_in),
    .tail_valid(tail_valid),
    .tail_data (tail_count)
  );
  assign hit = active & tail_valid & |found_in;
  assign counter_en = (state == S_RUN) & enable_switch & ~counter_done & ~hit;
  assign running = state == S_RUN;
  assign found = state == S_FOUND;
  assign exhausted = state == S_EXHAUSTED;
  // The drain lasts PIPE_DEPTH cycles so the hit of the terminal count lands while still in DRAIN.
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      drain_cnt <= '0;
      result <= '0;
      found_mask <= '0;
    end else if (hit) begin
      state <= S_FOUND;
      result <= {tail_count, lowest_lane(found_in)};
      found_mask <= found_in;
    end else
      case (state)
        S_IDLE, S_PAUSE: if (start && enable_switch) state <= S_RUN;
        S_RUN:
          if (!enable_switch) state <= S_PAUSE;
          else if (counter_done) begin
            state <= S_DRAIN;
            drain_cnt <= DW'(PIPE_DEPTH);
          end
        S_DRAIN: begin
          if (drain_cnt <= DW'(1)) state <= S_EXHAUSTED;
          drain_cnt <= (drain_cnt == '0) ? '0 : drain_cnt - 1'b1;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_search_controller.sv
// tb_search_controller: directed and randomized checks of search_controller against a queue-based reference model.
module tb_search_controller;
  localparam int D = 65;
  localparam logic [28:0] MAX = '1;
  logic CLK = 0, reset = 0, start = 0, sw = 0, done;
  logic [28:0] cnt = '0;
  logic [7:0] fin = '0;
  logic counter_en, running, found, exhausted;
  logic [31:0] result;
  logic [7:0] found_mask;
  int vectors = 0, errors = 0, cyc = 0;
  typedef enum {P_IDLE, P_RUN, P_PAUSE, P_DRAIN, P_FOUND, P_EXH} phase_t;
  typedef struct packed {logic v; logic [28:0] c;} ent_t;
  phase_t ph;
  int exh_at;
  logic [31:0] e_res;
  logic [7:0] e_mask;
  ent_t hist[$];

  assign done = cnt == MAX;
  always #5 CLK = ~CLK;

  search_controller dut (
    .CLK(CLK), .reset(reset), .start(start), .enable_switch(sw), .count_in(cnt),
    .counter_done(done), .found_in(fin), .counter_en(counter_en), .running(running),
    .found(found), .exhausted(exhausted), .result(result), .found_mask(found_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic do_reset();
    reset = 1; start = 0; fin = '0;
    #1;
    ph = P_IDLE; e_res = '0; e_mask = '0;
    hist.delete();
    repeat (D) hist.push_back('0);
    chk("rst_en", counter_en, 0);
    chk("rst_running", running, 0);
    chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_result", result, 0);
    chk("rst_mask", found_mask, 0);
    @(posedge CLK);
    #1 reset = 0;
  endtask

  // One clock: check the combinational enable, advance the model, then check registered outputs.
  task automatic step();
    ent_t t;
    logic h, act, en, d;
    #2;
    t = hist[0];
    act = ph inside {P_RUN, P_PAUSE, P_DRAIN};
    h = act && t.v && fin != 0;
    d = done;
    en = ph == P_RUN && sw && !d && !h;
    chk("counter_en", counter_en, en);
    @(posedge CLK);
    cyc++;
    void'(hist.pop_front());
    hist.push_back('{v: act, c: cnt});
    if (h) begin
      ph = P_FOUND; e_res = {t.c, lowest(fin)}; e_mask = fin;
    end else
      case (ph)
        P_IDLE, P_PAUSE: if (start && sw) ph = P_RUN;
        P_RUN:
          if (!sw) ph = P_PAUSE;
          else if (d) begin ph = P_DRAIN; exh_at = cyc + D; end
        P_DRAIN: if (cyc == exh_at) ph = P_EXH;
        default: ;
      endcase
    #1;
    if (en) cnt++;
    start = 0;
    chk("running", running, ph == P_RUN);
    chk("found", found, ph == P_FOUND);
    chk("exhausted", exhausted, ph == P_EXH);
    chk("result", result, e_res);
    chk("found_mask", found_mask, e_mask);
  endtask

  task automatic run_hit(input logic [28:0] target, input logic [7:0] mask, input int maxc);
    for (int i = 0; i < maxc && ph != P_FOUND; i++) begin
      fin = (hist[0].v && hist[0].c == target) ? mask : 8'h00;
      step();
    end
    fin = '0;
    chk("hit_reached", found, 1);
  endtask

  initial begin
    logic [28:0] base;
    logic [7:0] m;
    int ds, es;
    do_reset();
    // single lane match
    cnt = 29'h0ABCDE0; sw = 1; start = 1;
    run_hit(29'h0ABCDEF, 8'h20, 200);
    chk("t1_result", result, 32'h055E6F7D);
    chk("t1_mask", found_mask, 32'h20);
    chk("t1_en", counter_en, 0);
    // multiple lanes: lowest index wins
    do_reset();
    cnt = '0; start = 1;
    run_hit(29'h0, 8'h94, 200);
    chk("t2_result", result, 32'h00000002);
    chk("t2_mask", found_mask, 32'h94);
    // garbage found flags before any start
    do_reset();
    repeat (D + 5) begin fin = 8'($urandom_range(1, 255)); step(); end
    fin = '0;
    chk("t3_idle", {running, found, exhausted}, 0);
    // exhaustion after drain
    do_reset();
    cnt = MAX - 4; start = 1; ds = -1; es = -1;
    for (int i = 0; i < 200 && es < 0; i++) begin
      step();
      if (ds < 0 && ph == P_DRAIN) ds = i;
      if (es < 0 && exhausted) es = i;
    end
    chk("t4_exhausted", exhausted, 1);
    chk("t4_drain_len", es - ds, D);
    chk("t4_en", counter_en, 0);
    // hit on the last drain cycle
    do_reset();
    cnt = MAX - 4; start = 1; m = 8'($urandom_range(1, 255));
    run_hit(MAX, m, 200);
    chk("t4b_exhausted", exhausted, 0);
    chk("t4b_result", result, {MAX, lowest(m)});
    // pause with in-flight hit, start ignored while switch low
    do_reset();
    cnt = 29'($urandom_range(0, 32'h1FFF0000)); base = cnt; start = 1;
    repeat (10) step();
    sw = 0;
    step();
    chk("t5_en", counter_en, 0);
    start = 1;
    step();
    chk("t5_paused", running, 0);
    m = 8'($urandom_range(1, 255));
    run_hit(base + 29'd3, m, 200);
    chk("t5_result", result, {base + 29'd3, lowest(m)});
    // reset from FOUND, then clean restart
    do_reset();
    cnt = 29'd100; sw = 1; start = 1;
    run_hit(29'd103, 8'h80, 200);
    chk("t6_result", result, {29'd103, 3'd7});
    // reset from DRAIN, then clean restart
    do_reset();
    cnt = MAX - 2; start = 1;
    repeat (20) step();
    chk("t6_draining", {running, exhausted}, 0);
    do_reset();
    cnt = 29'd7; start = 1;
    run_hit(29'd9, 8'h0C, 200);
    chk("t6b_result", result, {29'd9, 3'd2});
    // randomized runs
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cnt = (r == 3) ? MAX - 29'd40 : 29'($urandom_range(0, 100000));
      repeat (300) begin
        sw = $urandom_range(0, 9) != 0;
        start = $urandom_range(0, 7) == 0;
        fin = ($urandom_range(0, 149) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        step();
      end
      fin = '0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
